// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch stage.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam int              INSTR_BYTES      = 4;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous write, asynchronous head read, flush clears all entries.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [W-1:0]                 i_wdata,
    output logic [W-1:0]                 o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    // A push into a full buffer is allowed when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Prefetching fetch stage: credit-limited sequential requests, in-order response buffering,
// redirect flush with drop counting of stale in-flight responses.
module instruction_fetch_unit #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);
    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]   r_fetch_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    fetch_state_e      r_state;

    fetch_state_e      w_state_next;
    logic [CW-1:0]     w_drop_next;
    logic [CW-1:0]     w_occupancy;
    logic              w_credit;
    logic              w_req_fire;
    logic              w_resp_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [XLEN-1:0]   w_resp_pc;
    logic [2*XLEN-1:0] w_head;
    logic              w_unused;

    assign w_credit      = ({1'b0, w_occupancy} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign mem_req_valid = reset && !redirect_valid && w_credit;
    assign mem_req_addr  = mem_req_valid ? r_fetch_pc : '0;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    // In FETCH every in-flight request is contiguous ending at fetch_pc, so the oldest one
    // (the one answering now) sits outstanding words behind it.
    assign w_resp_pc   = r_fetch_pc - (XLEN'(r_outstanding) * XLEN'(INSTR_BYTES));
    assign w_resp_drop = redirect_valid || (r_state == DRAIN);
    assign w_push      = mem_resp_valid && !w_resp_drop;

    assign inst_valid = !w_fifo_empty;
    assign inst_data  = inst_valid ? w_head[XLEN-1:0]      : '0;
    assign inst_pc    = inst_valid ? w_head[2*XLEN-1:XLEN] : '0;
    assign w_pop      = inst_valid && inst_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (2*XLEN)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata ({w_resp_pc, mem_resp_data}),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_occupancy)
    );

    always_comb begin
        w_drop_next  = r_drop_cnt;
        w_state_next = r_state;
        // A redirect never issues a request, and a same-cycle response is already gone.
        if (redirect_valid) begin
            w_drop_next = r_outstanding - CW'(mem_resp_valid);
        end else if (mem_resp_valid && (r_drop_cnt != '0)) begin
            w_drop_next = r_drop_cnt - CW'(1);
        end
        case (r_state)
            FETCH:   if (redirect_valid && (w_drop_next != '0)) w_state_next = DRAIN;
            DRAIN:   if (w_drop_next == '0) w_state_next = FETCH;
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_state       <= FETCH;
        end else begin
            r_state       <= w_state_next;
            r_drop_cnt    <= w_drop_next;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(mem_resp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    assign w_unused = &{1'b0, redirect_pc[1:0], w_fifo_full};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit with a transaction-level memory and fetch model.
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    instruction_fetch_unit #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } req_t;

    req_t        memq[$];     // accepted requests awaiting their memory response
    logic [31:0] m_buf[$];    // PCs the datapath should still receive, in order
    logic [31:0] g_acc[$];    // accepted request addresses
    logic [31:0] g_deliv[$];  // delivered instruction PCs
    logic [31:0] m_pc;
    int          m_ep;
    int          cyc;
    int          checks;
    int          errors;
    int          g_rdy_pct;
    int          g_irdy_pct;
    int          g_lat_min;
    int          g_lat_max;
    bit          p_stall;
    logic [31:0] p_addr;
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_inst_valid;
    logic        s_resp;
    logic        s_irdy;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0013;
    endfunction

    task automatic model_clear();
        memq.delete();
        m_buf.delete();
        m_pc    = RESET_PC;
        m_ep    = 0;
        p_stall = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check outputs, advance the model.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit   rv;
        bit   exp_rv;
        bit   exp_iv;
        req_t e;
        int   lat;
        rv             = (memq.size() > 0) && (memq[0].due <= cyc);
        mem_resp_valid = rv;
        mem_resp_data  = rv ? memf(memq[0].addr) : 32'h0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_req_ready  = ($urandom_range(99) < g_rdy_pct);
        inst_ready     = ($urandom_range(99) < g_irdy_pct);
        #1;
        exp_rv = !redir && ((m_buf.size() + memq.size()) < DEPTH);
        checks++;
        if (mem_req_valid !== exp_rv) begin
            errors++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, mem_req_valid, exp_rv);
        end
        if (exp_rv) begin
            checks++;
            if (mem_req_addr !== m_pc) begin
                errors++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, mem_req_addr, m_pc);
            end
            if (p_stall) begin
                checks++;
                if (mem_req_addr !== p_addr) begin
                    errors++;
                    $display("FAIL addr_stable cyc=%0d got=%h exp=%h", cyc, mem_req_addr, p_addr);
                end
            end
        end
        exp_iv = (m_buf.size() > 0);
        checks++;
        if (inst_valid !== exp_iv) begin
            errors++;
            $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_iv);
        end
        if (exp_iv) begin
            checks++;
            if (inst_pc !== m_buf[0] || inst_data !== memf(m_buf[0])) begin
                errors++;
                $display("FAIL inst cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                         cyc, inst_pc, inst_data, m_buf[0], memf(m_buf[0]));
            end
        end
        s_req_valid  = mem_req_valid;
        s_req_addr   = mem_req_addr;
        s_inst_valid = inst_valid;
        s_resp       = rv;
        s_irdy       = inst_ready;
        if (exp_iv && inst_ready) begin
            g_deliv.push_back(m_buf[0]);
            void'(m_buf.pop_front());
        end
        if (rv) begin
            e = memq.pop_front();
            if (!redir && e.ep == m_ep) m_buf.push_back(e.addr);
        end
        p_stall = exp_rv && !mem_req_ready;
        p_addr  = m_pc;
        if (exp_rv && mem_req_ready) begin
            lat    = $urandom_range(g_lat_max, g_lat_min);
            e.addr = m_pc;
            e.due  = cyc + lat;
            e.ep   = m_ep;
            memq.push_back(e);
            g_acc.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_buf.delete();
            m_pc = rpc & ~32'h3;
            m_ep++;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || inst_valid !== 1'b0 ||
            inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rv=%b addr=%h iv=%b data=%h pc=%h exp all 0",
                     mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc);
        end
        @(negedge clk);
        reset = 1'b1;
        g_rdy_pct = 100; g_irdy_pct = 100; g_lat_min = 1; g_lat_max = 1;
        step(1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req got valid=%b addr=%h exp valid=1 addr=%h",
                     s_req_valid, s_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int  n;
        bit  ok;
        do_reset();
        g_rdy_pct = 100; g_irdy_pct = 100; g_lat_min = 1; g_lat_max = 1;
        g_deliv.delete();
        repeat (4) step(1'b0, 32'h0);
        n = 0;
        repeat (16) begin
            step(1'b0, 32'h0);
            if (s_inst_valid) n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL stream_no_gaps got=%0d valid cycles exp=16", n);
        end
        ok = (g_deliv.size() >= 16);
        for (int i = 0; i < g_deliv.size(); i++) if (g_deliv[i] !== 32'(i * 4)) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_order got %0d delivered, first=%h exp sequential from 0",
                     g_deliv.size(), (g_deliv.size() > 0) ? g_deliv[0] : 32'hx);
        end
    endtask

    task automatic test_credit();
        do_reset();
        g_rdy_pct = 100; g_irdy_pct = 0; g_lat_min = 1; g_lat_max = 1;
        g_acc.delete();
        repeat (12) step(1'b0, 32'h0);
        checks++;
        if (g_acc.size() != DEPTH || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL credit_fill got reqs=%0d valid=%b exp reqs=%0d valid=0",
                     g_acc.size(), s_req_valid, DEPTH);
        end
        g_acc.delete();
        g_irdy_pct = 100;
        step(1'b0, 32'h0);
        g_irdy_pct = 0;
        repeat (8) step(1'b0, 32'h0);
        checks++;
        if (g_acc.size() != 1) begin
            errors++;
            $display("FAIL credit_one_more got reqs=%0d exp=1", g_acc.size());
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        g_rdy_pct = 100; g_irdy_pct = 100; g_lat_min = 4; g_lat_max = 4;
        repeat (3) step(1'b0, 32'h0);
        g_acc.delete();
        g_deliv.delete();
        step(1'b1, 32'h0000_0103);
        repeat (20) step(1'b0, 32'h0);
        checks++;
        if (g_acc.size() == 0 || g_acc[0] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_addr got=%h exp=00000100", (g_acc.size() > 0) ? g_acc[0] : 32'hx);
        end
        checks++;
        if (g_deliv.size() == 0 || g_deliv[0] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_first_inst got=%h exp=00000100",
                     (g_deliv.size() > 0) ? g_deliv[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back_redirect();
        bit ok;
        do_reset();
        g_rdy_pct = 100; g_irdy_pct = 100; g_lat_min = 3; g_lat_max = 3;
        repeat (4) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0200);
        checks++;
        if (!(s_resp && s_inst_valid && s_irdy)) begin
            errors++;
            $display("FAIL redirect_collide got resp=%b iv=%b irdy=%b exp all 1", s_resp, s_inst_valid, s_irdy);
        end
        step(1'b0, 32'h0);
        checks++;
        if (s_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty got=%b exp=0", s_inst_valid);
        end
        step(1'b1, 32'h0000_0300);
        g_deliv.delete();
        repeat (15) step(1'b0, 32'h0);
        ok = (g_deliv.size() > 0) && (g_deliv[0] === 32'h300);
        for (int i = 0; i < g_deliv.size(); i++) if (g_deliv[i] < 32'h300) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_redirect got n=%0d first=%h exp first=00000300",
                     g_deliv.size(), (g_deliv.size() > 0) ? g_deliv[0] : 32'hx);
        end
    endtask

    task automatic test_wrap_random();
        do_reset();
        g_rdy_pct = 50; g_irdy_pct = 70; g_lat_min = 1; g_lat_max = 4;
        repeat (3) step(1'b0, 32'h0);
        g_acc.delete();
        step(1'b1, 32'hFFFF_FFF8);
        repeat (60) step(1'b0, 32'h0);
        checks++;
        if (g_acc.size() < 3 || g_acc[0] !== 32'hFFFF_FFF8 || g_acc[1] !== 32'hFFFF_FFFC ||
            g_acc[2] !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap got n=%0d first=%h exp FFFFFFF8,FFFFFFFC,00000000",
                     g_acc.size(), (g_acc.size() > 0) ? g_acc[0] : 32'hx);
        end
        repeat (300) step($urandom_range(19) == 0, $urandom());
    endtask

    task automatic test_reset_midop();
        int guard;
        do_reset();
        g_rdy_pct = 100; g_irdy_pct = 0; g_lat_min = 4; g_lat_max = 4;
        guard = 0;
        while (!(m_buf.size() == 2 && memq.size() == 2) && guard < 20) begin
            step(1'b0, 32'h0);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL midop_setup got buf=%0d out=%0d exp buf=2 out=2", m_buf.size(), memq.size());
        end
        reset          = 1'b0;
        mem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || inst_valid !== 1'b0 ||
            inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset got rv=%b addr=%h iv=%b data=%h pc=%h exp all 0",
                     mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc);
        end
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL midop_restart got valid=%b addr=%h exp valid=1 addr=%h",
                     s_req_valid, s_req_addr, RESET_PC);
        end
        repeat (10) step(1'b0, 32'h0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        reset          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        model_clear();
        test_reset();
        test_stream();
        test_credit();
        test_redirect_drop();
        test_back_to_back_redirect();
        test_wrap_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
